// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the floating-point adder.
// Latency: none (types, constants and one combinational helper).
// Backpressure: not applicable.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int MANT_W  = FRAC_W + 1;          // hidden bit + fraction
  localparam int EXP_MAX = 2 * BIAS + 1;        // all-ones exponent (inf/NaN)
  localparam int LZC_W   = $clog2(MANT_W + 1);  // counts 0..MANT_W

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;

  // Unpacked operand: mantissa carries the hidden bit, zero for flushed values.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_op_t;

  // Denormals are flushed to a zero of the same sign.
  function automatic fp_op_t fp_unpack(input logic [31:0] v);
    fp_op_t o;
    o.sign    = v[31];
    o.exp     = v[30:23];
    o.is_zero = (v[30:23] == '0);
    o.is_inf  = (v[30:23] == '1) && (v[22:0] == '0);
    o.is_nan  = (v[30:23] == '1) && (v[22:0] != '0);
    o.mant    = o.is_zero ? '0 : {1'b1, v[22:0]};
    return o;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over the 24-bit mantissa field.
// Latency: combinational.
// Backpressure: not applicable.
//
// Ports:
//   i_dat  mantissa bits, MSB first
//   o_cnt  number of leading zeros; MANT_W when i_dat is all zero
module fp_lzc
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] i_dat,
  output logic [LZC_W-1:0]  o_cnt
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (i_dat[i]) o_cnt = LZC_W'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_sub.sv
// IEEE-754 binary32 adder, round-to-nearest-even, flush-to-zero.
// Latency: 7 cycles (operands captured at edge N, result after edge N+7).
// Backpressure: none; accepts one operation every cycle, never stalls.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-high reset, clears every pipeline register
//   dataa   operand A (binary32)
//   datab   operand B (binary32)
//   result  registered A+B (binary32)
module fp_add_sub
  import fp_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  // Special-case outcome decided early and carried alongside the datapath.
  typedef struct packed {
    logic        special;   // NaN or inf involved: res overrides datapath
    logic [31:0] res;
    logic        neg_zero;  // both operands were negative zeros
  } side_t;

  // ---------------- pipeline registers ----------------
  logic [31:0]       r0_a, r0_b;
  fp_op_t            r1_a, r1_b;
  logic              r2_sign_l, r2_sign_s;
  logic [EXP_W-1:0]  r2_exp, r2_shift;
  logic [MANT_W-1:0] r2_mant_l, r2_mant_s;
  side_t             r2_side;
  logic              r3_sign, r3_sub;
  logic [EXP_W-1:0]  r3_exp;
  logic [26:0]       r3_mant_l, r3_mant_s;   // {mant, guard, round, sticky}
  side_t             r3_side;
  logic              r4_sign;
  logic [EXP_W-1:0]  r4_exp;
  logic [27:0]       r4_sum;                 // extra carry bit on top
  side_t             r4_side;
  logic              r5_sign, r5_zero;
  logic [9:0]        r5_exp;                 // bit 9 set means underflowed
  logic [26:0]       r5_norm;
  side_t             r5_side;
  logic              r6_sign, r6_zero;
  logic [9:0]        r6_exp;
  logic [FRAC_W-1:0] r6_frac;
  side_t             r6_side;
  logic [31:0]       r_result;

  // ---------------- stage 1: unpack ----------------
  fp_op_t w1_a, w1_b;
  assign w1_a = fp_unpack(r0_a);
  assign w1_b = fp_unpack(r0_b);

  // ---------------- stage 2: compare and swap ----------------
  // Ordering by full magnitude keeps the later subtraction non-negative.
  logic              w2_a_big, w2_sign_l, w2_sign_s;
  logic [EXP_W-1:0]  w2_exp_l, w2_exp_s;
  logic [MANT_W-1:0] w2_mant_l, w2_mant_s;
  side_t             w2_side;

  assign w2_a_big  = (r1_a.exp > r1_b.exp) ||
                     ((r1_a.exp == r1_b.exp) && (r1_a.mant >= r1_b.mant));
  assign w2_sign_l = w2_a_big ? r1_a.sign : r1_b.sign;
  assign w2_sign_s = w2_a_big ? r1_b.sign : r1_a.sign;
  assign w2_exp_l  = w2_a_big ? r1_a.exp  : r1_b.exp;
  assign w2_exp_s  = w2_a_big ? r1_b.exp  : r1_a.exp;
  assign w2_mant_l = w2_a_big ? r1_a.mant : r1_b.mant;
  assign w2_mant_s = w2_a_big ? r1_b.mant : r1_a.mant;

  always_comb begin
    w2_side          = '0;
    w2_side.special  = r1_a.is_nan | r1_b.is_nan | r1_a.is_inf | r1_b.is_inf;
    w2_side.neg_zero = r1_a.is_zero & r1_b.is_zero & r1_a.sign & r1_b.sign;
    if (r1_a.is_nan || r1_b.is_nan ||
        (r1_a.is_inf && r1_b.is_inf && (r1_a.sign != r1_b.sign)))
      w2_side.res = QNAN;
    else if (r1_a.is_inf)
      w2_side.res = r1_a.sign ? NINF : PINF;
    else if (r1_b.is_inf)
      w2_side.res = r1_b.sign ? NINF : PINF;
  end

  // ---------------- stage 3: align ----------------
  // The wide shifter keeps every shifted-out bit so sticky is exact; past 25
  // positions nothing but sticky can survive.
  logic [49:0] w3_wide;
  logic [26:0] w3_mant_s;
  assign w3_wide = {r2_mant_s, 26'd0} >> r2_shift;
  always_comb begin
    if (r2_shift >= 8'd26)
      w3_mant_s = {26'd0, |r2_mant_s};
    else
      w3_mant_s = {w3_wide[49:24], |w3_wide[23:0]};
  end

  // ---------------- stage 4: add / subtract ----------------
  logic [27:0] w4_sum;
  assign w4_sum = r3_sub ? ({1'b0, r3_mant_l} - {1'b0, r3_mant_s})
                         : ({1'b0, r3_mant_l} + {1'b0, r3_mant_s});

  // ---------------- stage 5: normalize ----------------
  // A count of 24 with the guard bit set only arises from a one-position
  // subtraction, where round/sticky are zero, so a plain shift is exact.
  logic [LZC_W-1:0] w5_lz;
  logic [26:0]      w5_norm;
  logic [9:0]       w5_exp;

  fp_lzc u_lzc (
    .i_dat (r4_sum[26:3]),
    .o_cnt (w5_lz)
  );

  always_comb begin
    if (r4_sum[27]) begin
      w5_norm = {r4_sum[27:2], r4_sum[1] | r4_sum[0]};
      w5_exp  = {2'b00, r4_exp} + 10'd1;
    end else begin
      w5_norm = r4_sum[26:0] << w5_lz;
      w5_exp  = {2'b00, r4_exp} - {{(10-LZC_W){1'b0}}, w5_lz};
    end
  end

  // ---------------- stage 6: round ----------------
  logic              w6_up;
  logic [MANT_W:0]   w6_mant;
  logic [FRAC_W-1:0] w6_frac;
  logic [9:0]        w6_exp;
  assign w6_up   = r5_norm[2] & (r5_norm[1] | r5_norm[0] | r5_norm[3]);
  assign w6_mant = {1'b0, r5_norm[26:3]} + {{MANT_W{1'b0}}, w6_up};
  // Rounding carry-out leaves 1.000..0 one binade higher.
  assign w6_frac = w6_mant[MANT_W] ? w6_mant[MANT_W-1:1] : w6_mant[FRAC_W-1:0];
  assign w6_exp  = w6_mant[MANT_W] ? (r5_exp + 10'd1) : r5_exp;

  // ---------------- stage 7: pack ----------------
  logic [31:0] w7_result;
  always_comb begin
    if (r6_side.special)
      w7_result = r6_side.res;
    else if (r6_zero)
      w7_result = {r6_side.neg_zero, 31'd0};
    else if (r6_exp[9] || (r6_exp == 10'd0))
      w7_result = '0;
    else if (r6_exp >= 10'(EXP_MAX))
      w7_result = r6_sign ? NINF : PINF;
    else
      w7_result = {r6_sign, r6_exp[EXP_W-1:0], r6_frac};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r0_a <= '0;  r0_b <= '0;
      r1_a <= '0;  r1_b <= '0;
      r2_sign_l <= 1'b0;  r2_sign_s <= 1'b0;  r2_exp <= '0;  r2_shift <= '0;
      r2_mant_l <= '0;  r2_mant_s <= '0;  r2_side <= '0;
      r3_sign <= 1'b0;  r3_sub <= 1'b0;  r3_exp <= '0;
      r3_mant_l <= '0;  r3_mant_s <= '0;  r3_side <= '0;
      r4_sign <= 1'b0;  r4_exp <= '0;  r4_sum <= '0;  r4_side <= '0;
      r5_sign <= 1'b0;  r5_zero <= 1'b0;  r5_exp <= '0;  r5_norm <= '0;  r5_side <= '0;
      r6_sign <= 1'b0;  r6_zero <= 1'b0;  r6_exp <= '0;  r6_frac <= '0;  r6_side <= '0;
      r_result <= '0;
    end else begin
      r0_a <= dataa;
      r0_b <= datab;

      r1_a <= w1_a;
      r1_b <= w1_b;

      r2_sign_l <= w2_sign_l;
      r2_sign_s <= w2_sign_s;
      r2_exp    <= w2_exp_l;
      r2_shift  <= w2_exp_l - w2_exp_s;
      r2_mant_l <= w2_mant_l;
      r2_mant_s <= w2_mant_s;
      r2_side   <= w2_side;

      r3_sign   <= r2_sign_l;
      r3_sub    <= r2_sign_l ^ r2_sign_s;
      r3_exp    <= r2_exp;
      r3_mant_l <= {r2_mant_l, 3'b000};
      r3_mant_s <= w3_mant_s;
      r3_side   <= r2_side;

      r4_sign <= r3_sign;
      r4_exp  <= r3_exp;
      r4_sum  <= w4_sum;
      r4_side <= r3_side;

      r5_sign <= r4_sign;
      r5_zero <= (r4_sum == '0);
      r5_exp  <= w5_exp;
      r5_norm <= w5_norm;
      r5_side <= r4_side;

      r6_sign <= r5_sign;
      r6_zero <= r5_zero;
      r6_exp  <= w6_exp;
      r6_frac <= w6_frac;
      r6_side <= r5_side;

      r_result <= w7_result;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_fp_add_sub.sv
// Bench for fp_add_sub: directed table, exact-latency stream, randomized
// operands against an exact-arithmetic reference, and mid-stream reset.
module tb_fp_add_sub;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dataa, datab, result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  fp_add_sub dut (
    .clock  (clock),
    .reset  (reset),
    .dataa  (dataa),
    .datab  (datab),
    .result (result)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] y; } vec_t;
  typedef struct { logic [31:0] y; int id; } pend_t;

  vec_t  tbl[21];
  pend_t q[$];

  // Reference: exact sum as a scaled integer (units of 2^-149), then
  // round-to-nearest-even to 24 significant bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic         sa, sb, sz;
    int           ea, eb, p, e, sh;
    logic [22:0]  fa, fb;
    logic [299:0] xa, xb, z, rem, half, one;
    logic [24:0]  m;
    one = 1;
    sa = a[31]; ea = int'(a[30:23]); fa = a[22:0];
    sb = b[31]; eb = int'(b[30:23]); fb = b[22:0];
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (sa == sb) ? a : 32'h7FC00000;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return (sa && sb) ? 32'h80000000 : 32'h0;
    xa = (ea == 0) ? '0 : ({276'd0, 1'b1, fa} << (ea - 1));
    xb = (eb == 0) ? '0 : ({276'd0, 1'b1, fb} << (eb - 1));
    if (sa == sb)      begin z = xa + xb; sz = sa; end
    else if (xa >= xb) begin z = xa - xb; sz = sa; end
    else               begin z = xb - xa; sz = sb; end
    if (z == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (z[i]) p = i;
    e = p - 22;
    if (e <= 0) return 32'h0;
    sh = p - 23;
    m = 25'(z >> sh);
    if (sh > 0) begin
      rem  = z & ((one << sh) - one);
      half = one << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 25'd1;
    end
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e >= 255) return {sz, 8'hFF, 23'd0};
    return {sz, 8'(e), m[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: result=%08h expected=%08h", name, act, exp_v);
  endtask

  // One cycle: compare the result due now, then present the next operands.
  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] y, input int id);
    pend_t e;
    @(negedge clock);
    if (q.size() >= 8) begin
      e = q.pop_front();
      check($sformatf("pipe id=%0d", e.id), result, e.y);
    end
    dataa = a;
    datab = b;
    q.push_back('{y, id});
  endtask

  // Reset with whatever operands are on the inputs; in-flight work is dropped
  // and the flushed pipeline must only yield zeros.
  task automatic do_reset(input int tag);
    @(negedge clock);
    reset = 1'b1;
    q.delete();
    @(negedge clock);
    check($sformatf("reset_edge1 tag=%0d", tag), result, 32'h0);
    @(negedge clock);
    check($sformatf("reset_edge2 tag=%0d", tag), result, 32'h0);
    reset = 1'b0;
    dataa = 32'h0;
    datab = 32'h0;
    for (int i = 0; i < 8; i++) q.push_back('{32'h0, -100 * tag - i});
  endtask

  task automatic rand_pair(output logic [31:0] a, output logic [31:0] b);
    int mode;
    mode = $urandom_range(0, 3);
    a = $urandom;
    b = $urandom;
    case (mode)
      1: begin
        b = {~a[31], a[30:23], 23'($urandom)};
        if ($urandom_range(0, 3) == 0) b = a ^ 32'h80000000;
      end
      2: b = {1'($urandom), 8'(a[30:23] - 8'($urandom_range(0, 30))), 23'($urandom)};
      3: begin
        a[30:23] = 8'($urandom_range(250, 254));
        b = {a[31], 8'($urandom_range(250, 254)), 23'($urandom)};
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    dataa = 32'h0;
    datab = 32'h0;

    tbl[0]  = '{32'h00000001, 32'h00000002, 32'h00000000};
    tbl[1]  = '{32'h0000014C, 32'h00000016, 32'h00000000};
    tbl[2]  = '{32'h3F800000, 32'h40000000, 32'h40400000};
    tbl[3]  = '{32'h3FC00000, 32'hBF000000, 32'h3F800000};
    tbl[4]  = '{32'h4B800000, 32'h3F800000, 32'h4B800000};
    tbl[5]  = '{32'h4B800001, 32'h3F800000, 32'h4B800002};
    tbl[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    tbl[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
    tbl[8]  = '{32'h3F800000, 32'hBF800000, 32'h00000000};
    tbl[9]  = '{32'h80000000, 32'h80000000, 32'h80000000};
    tbl[10] = '{32'h80000001, 32'h80000000, 32'h80000000};
    tbl[11] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000};
    tbl[12] = '{32'hFF800000, 32'h42000000, 32'hFF800000};
    tbl[13] = '{32'h7F800000, 32'h7F800000, 32'h7F800000};
    tbl[14] = '{32'h00800001, 32'h80800000, 32'h00000000};
    tbl[15] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000};
    tbl[16] = '{32'h3F800000, 32'h33800000, 32'h3F800000};
    tbl[17] = '{32'h3F800000, 32'h33800001, 32'h3F800001};
    tbl[18] = '{32'h3F800000, 32'hB3800000, 32'h3F7FFFFF};
    tbl[19] = '{32'h00000000, 32'h80000000, 32'h00000000};
    tbl[20] = '{32'h7F000000, 32'h7F000000, 32'h7F800000};

    do_reset(1);

    // Lone operation between idle zeros: must land on exactly the 7th edge.
    step(32'h3F800000, 32'h40000000, 32'h40400000, 900);
    for (int i = 0; i < 9; i++) step(32'h0, 32'h0, 32'h0, 901 + i);

    // Directed vectors, back to back.
    for (int i = 0; i < 21; i++) step(tbl[i].a, tbl[i].b, tbl[i].y, i);

    // Randomized operands against the reference.
    for (int i = 0; i < 300; i++) begin
      rand_pair(ra, rb);
      step(ra, rb, ref_add(ra, rb), 1000 + i);
    end

    // Ten-cycle stream, then reset while it is still in flight.
    for (int i = 0; i < 10; i++) begin
      ra = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
      rb = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
      step(ra, rb, ref_add(ra, rb), 2000 + i);
    end
    do_reset(2);

    // Traffic resumes cleanly after reset.
    for (int i = 0; i < 10; i++) begin
      rand_pair(ra, rb);
      step(ra, rb, ref_add(ra, rb), 3000 + i);
    end
    for (int i = 0; i < 8; i++) step(32'h0, 32'h0, 32'h0, 4000 + i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_add_sub.md
FP_ADD_SUB -- requirements
Module: fp_add_sub

Interface
REQ-001 Parameters: none; latency and format are fixed.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 dataa  input  32  operand A, IEEE-754 binary32 (sign[31], exp[30:23], frac[22:0]).
REQ-005 datab  input  32  operand B, same format.
REQ-006 result  output  32  registered sum A+B, binary32.

Function
REQ-007 The block SHALL compute result = dataa + datab (addition only; no add/sub select input; subtraction is done by the caller flipping datab[31]).
REQ-008 The block SHALL be fully pipelined with a fixed latency of 7 clock cycles: operands sampled at edge N appear on result after edge N+7.
REQ-009 Throughput SHALL be one operation per cycle; there is no handshake and no stall.
REQ-010 The pipeline stages SHALL be:
- unpack and classify;
- exponent compare and operand swap;
- alignment right shift with guard/round/sticky;
- signed mantissa add/subtract;
- leading-zero count and normalize;
- round;
- pack and special-case select.
REQ-011 Rounding SHALL be round-to-nearest, ties-to-even.
REQ-012 Denormal inputs (exp=0, frac!=0) SHALL be treated as zero of the same sign (flush-to-zero).
REQ-013 Results below the minimum normal magnitude SHALL be flushed to +0.
REQ-014 Exact cancellation (x + -x) SHALL give +0; (-0)+(-0) SHALL give -0.
REQ-015 Alignment shifts of 26 or more SHALL reduce the smaller operand to sticky only.
REQ-016 Exponent overflow after rounding SHALL give infinity with the sign of the exact sum (0x7F800000 / 0xFF800000).
REQ-017 Any NaN input, or +inf + -inf, SHALL give the canonical quiet NaN 0x7FC00000.
REQ-018 inf + finite SHALL give that infinity; inf + same-sign inf SHALL give that infinity.
REQ-019 No status flags are output; overflow, underflow and NaN are visible only through result encoding.

Reset
REQ-020 While reset is high at a clock edge, all pipeline registers SHALL clear to zero.
REQ-021 result SHALL read 0x00000000 from the first edge with reset high until 7 edges after valid operands are presented following reset deassertion.
REQ-022 Operations in flight when reset asserts SHALL be discarded; no partial result SHALL emerge.
REQ-023 Before the first reset, result is undefined; benches SHALL reset first.

Structure
REQ-024 A shared package fp_pkg SHALL hold:
- the field widths (EXP_W=8, FRAC_W=23, BIAS=127);
- the QNAN/PINF/NINF constants;
- a typedef for the unpacked operand (sign, exp, 24-bit mantissa, is_zero, is_inf, is_nan).
REQ-025 A single sub-module fp_lzc (24-bit leading-zero counter, combinational) SHALL be used by the normalize stage; everything else lives in fp_add_sub.

Verification
REQ-026 Denormal flush: dataa=0x00000001, datab=0x00000002 -> result 0x00000000 after 7 cycles; likewise 0x0000014C + 0x00000016 -> 0x00000000.
REQ-027 Normal add: 1.0 (0x3F800000) + 2.0 (0x40000000) -> 0x40400000; 1.5 (0x3FC00000) + -0.5 (0xBF000000) -> 0x3F800000.
REQ-028 Rounding tie: 0x4B800000 (2^24) + 0x3F800000 (1.0) -> 0x4B800000 (tie to even); 0x4B800001 + 0x3F800000 -> 0x4B800002.
REQ-029 Specials:
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000;
- 0x7F800000 + 0xFF800000 -> 0x7FC00000;
- 0x3F800000 + 0xBF800000 -> 0x00000000.
REQ-030 Pipelining and reset: drive a new operand pair every cycle for 10 cycles and check each result exactly 7 cycles later in order; then assert reset mid-stream and check result=0 on the next edge with no stale results emerging.
